// File: rtl/prog_loader.sv
// Program ROM loader: assembles a byte stream (count, instr/arg pairs) into program memory writes and holds the CPU meanwhile.
// Optional trailing checksum byte and CHECK state are enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [WIDTH-1:0]      wr_instr,
    output logic [WIDTH-1:0]      wr_arg,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned DEPTH = 32'(1) << ADDR_WIDTH;

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_INSTR, S_ARG, S_CHECK, S_DONE, S_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_INSTR, S_ARG, S_DONE, S_ERR
    } state_t;
`endif

    state_t                state;
    logic [WIDTH-1:0]      remaining;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      instr_q;
    logic [WIDTH-1:0]      arg_q;
    logic                  pend;
    logic                  xfer;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0]      sum;
`endif

    always_comb begin
        in_ready = (state == S_COUNT) || (state == S_INSTR) || (state == S_ARG);
`ifdef PROG_LOADER_CHECKSUM_EN
        if (state == S_CHECK) in_ready = 1'b1;
`endif
    end

    assign xfer = in_valid && in_ready;

    // The write pulse trails the arg handshake by one edge so a reset in between cancels it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            remaining <= '0;
            addr      <= '0;
            instr_q   <= '0;
            arg_q     <= '0;
            pend      <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_instr  <= '0;
            wr_arg    <= '0;
            cpu_hold  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            wr_en <= pend;
            pend  <= 1'b0;
            if (pend) begin
                wr_addr  <= addr;
                wr_instr <= instr_q;
                wr_arg   <= arg_q;
                addr     <= addr + 1'b1;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            if (xfer) sum <= sum + in_data;
`endif
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state    <= S_COUNT;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        cpu_hold <= 1'b1;
                        busy     <= 1'b1;
                        addr     <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum      <= '0;
`endif
                    end
                end
                S_COUNT: begin
                    if (xfer) begin
                        if (32'(in_data) > DEPTH) begin
                            state <= S_ERR;
                            err   <= 1'b1;
                            busy  <= 1'b0;
                        end else if (in_data == '0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state    <= S_CHECK;
`else
                            state    <= S_DONE;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            cpu_hold <= 1'b0;
`endif
                        end else begin
                            remaining <= in_data;
                            state     <= S_INSTR;
                        end
                    end
                end
                S_INSTR: begin
                    if (xfer) begin
                        instr_q <= in_data;
                        state   <= S_ARG;
                    end
                end
                S_ARG: begin
                    if (xfer) begin
                        arg_q     <= in_data;
                        pend      <= 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == WIDTH'(1)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state    <= S_CHECK;
`else
                            state    <= S_DONE;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            cpu_hold <= 1'b0;
`endif
                        end else begin
                            state <= S_INSTR;
                        end
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (xfer) begin
                        busy <= 1'b0;
                        if (in_data == sum) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: default-size instance (a) and a 4-word instance (b) share the byte stream.
module tb_prog_loader;

    logic       clk;
    logic       rst;
    logic       start_a;
    logic       start_b;
    logic [7:0] in_data;
    logic       in_valid;

    logic       in_ready_a, wr_en_a, cpu_hold_a, busy_a, done_a, err_a;
    logic [7:0] wr_addr_a, wr_instr_a, wr_arg_a;
    logic       in_ready_b, wr_en_b, cpu_hold_b, busy_b, done_b, err_b;
    logic [1:0] wr_addr_b;
    logic [7:0] wr_instr_b, wr_arg_b;

    int vectors     = 0;
    int miscompares = 0;

    logic [23:0] qa[$];
    logic [23:0] qb[$];

    prog_loader #(.WIDTH(8), .ADDR_WIDTH(8)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_instr(wr_instr_a),
        .wr_arg(wr_arg_a), .cpu_hold(cpu_hold_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    prog_loader #(.WIDTH(8), .ADDR_WIDTH(2)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_instr(wr_instr_b),
        .wr_arg(wr_arg_b), .cpu_hold(cpu_hold_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Capture write strobes as {addr, instr, arg}.
    always @(negedge clk) begin
        if (wr_en_a === 1'b1) qa.push_back({wr_addr_a, wr_instr_a, wr_arg_a});
        if (wr_en_b === 1'b1) qb.push_back({6'd0, wr_addr_b, wr_instr_b, wr_arg_b});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input bit sel);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit sel, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!(sel ? in_ready_b : in_ready_a) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("handshake", (n < 50) ? 32'd1 : 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_a_stream(input bit good_sum, input bit gaps);
        logic [7:0] s [6];
        s[0] = 8'h02; s[1] = 8'h10; s[2] = 8'h05; s[3] = 8'h20; s[4] = 8'h07;
        s[5] = good_sum ? 8'h3E : 8'h3F;
`ifdef PROG_LOADER_CHECKSUM_EN
        for (int i = 0; i < 6; i++) send(s[i], 1'b0, gaps ? int'($urandom_range(0, 3)) : 0);
`else
        for (int i = 0; i < 5; i++) send(s[i], 1'b0, gaps ? int'($urandom_range(0, 3)) : 0);
`endif
    endtask

    task automatic check_a_writes(input string tag);
        repeat (3) @(negedge clk);
        check({tag, "_nwr"}, 32'(qa.size()), 32'd2);
        if (qa.size() == 2) begin
            check({tag, "_wr0"}, 32'(qa[0]), 32'h001005);
            check({tag, "_wr1"}, 32'(qa[1]), 32'h012007);
        end
        qa.delete();
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; in_data = 8'h00; in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ctl", {in_ready_a, wr_en_a, cpu_hold_a, busy_a, done_a, err_a}, 32'd0);
        check("rst_data", {wr_addr_a, wr_instr_a, wr_arg_a}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Nominal load
        do_start(1'b0);
        check("start_ctl", {in_ready_a, cpu_hold_a, busy_a, done_a, err_a}, 32'b11100);
        send_a_stream(1'b1, 1'b0);
        check("ok_ctl", {in_ready_a, cpu_hold_a, busy_a, done_a, err_a}, 32'b00010);
        check_a_writes("ok");

`ifdef PROG_LOADER_CHECKSUM_EN
        // Corrupt checksum: writes still happen, CPU stays held
        do_start(1'b0);
        send_a_stream(1'b0, 1'b0);
        check("bad_ctl", {in_ready_a, cpu_hold_a, busy_a, done_a, err_a}, 32'b01001);
        check_a_writes("bad");
`endif

        // Empty image
        do_start(1'b0);
        send(8'h00, 1'b0, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
        check("zero_mid", {in_ready_a, busy_a, done_a}, 32'b110);
        send(8'h00, 1'b0, 0);
`endif
        check("zero_ctl", {in_ready_a, cpu_hold_a, busy_a, done_a, err_a}, 32'b00010);
        repeat (3) @(negedge clk);
        check("zero_nwr", 32'(qa.size()), 32'd0);

        // Gapped valid
        do_start(1'b0);
        send_a_stream(1'b1, 1'b1);
        check("gap_ctl", {in_ready_a, cpu_hold_a, busy_a, done_a, err_a}, 32'b00010);
        check_a_writes("gap");

        // Start while busy is ignored, then reset right after first arg byte
        do_start(1'b0);
        send(8'h02, 1'b0, 0);
        send(8'h10, 1'b0, 0);
        do_start(1'b0);
        check("busy_start", {in_ready_a, busy_a}, 32'b11);
        send(8'h05, 1'b0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ctl", {in_ready_a, wr_en_a, cpu_hold_a, busy_a, done_a, err_a}, 32'd0);
        check("mid_rst_data", {wr_addr_a, wr_instr_a, wr_arg_a}, 32'd0);
        repeat (3) @(negedge clk);
        check("mid_rst_nwr", 32'(qa.size()), 32'd0);
        do_start(1'b0);
        send_a_stream(1'b1, 1'b0);
        check("reload_ctl", {cpu_hold_a, busy_a, done_a, err_a}, 32'b0010);
        check_a_writes("reload");

        // Small memory: count over DEPTH aborts at once
        do_start(1'b1);
        send(8'h05, 1'b1, 0);
        check("ovf_ctl", {in_ready_b, cpu_hold_b, busy_b, done_b, err_b}, 32'b01001);
        repeat (3) @(negedge clk);
        check("ovf_nwr", 32'(qb.size()), 32'd0);

        // Small memory: count equal to DEPTH fills it
        do_start(1'b1);
        check("full_start", {busy_b, err_b}, 32'b10);
        send(8'h04, 1'b1, 0);
        for (int i = 1; i <= 4; i++) begin
            send(8'(i), 1'b1, 0);
            send(8'(i), 1'b1, 0);
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send(8'h18, 1'b1, 0);
`endif
        check("full_ctl", {cpu_hold_b, busy_b, done_b, err_b}, 32'b0010);
        repeat (3) @(negedge clk);
        check("full_nwr", 32'(qb.size()), 32'd4);
        if (qb.size() == 4) begin
            check("full_wr0", 32'(qb[0]), 32'h000101);
            check("full_wr3", 32'(qb[3]), 32'h030404);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
